// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - requester command/response and APB bus bundle
interface apb_master_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DBITS = 32,
    parameter int ABITS = 16
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_write;
    logic [NREQ*ABITS-1:0] req_addr;
    logic [NREQ*DBITS-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [DBITS-1:0]      rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_tout;
    logic                  apb_sel;
    logic                  apb_enable;
    logic                  apb_write;
    logic [ABITS-1:0]      apb_addr;
    logic [DBITS-1:0]      apb_wdata;
    logic [DBITS-1:0]      apb_rdata;
    logic                  apb_ready;
    logic                  apb_slverr;
    logic [15:0]           err_cnt;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  apb_rdata, apb_ready, apb_slverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tout,
        output apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, err_cnt
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output apb_rdata, apb_ready, apb_slverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tout,
        input  apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, err_cnt
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter sharing one APB3 master port among NREQ requesters
module apb_master_arbiter #(
    parameter int NREQ  = 4,
    parameter int DBITS = 32,
    parameter int ABITS = 16,
    parameter int TOUT  = 256
) (
    input logic                  apb_clk,
    input logic                  apb_rst,
    apb_master_arbiter_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    generate
        if (NREQ < 2 || NREQ > 8 || TOUT < 1 || TOUT > 65535 || DBITS < 1 || ABITS < 1) begin : g_param_check
            $error("apb_master_arbiter: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    win_q;
    logic [PW-1:0]    idx;
    logic             any_valid;
    logic             write_q;
    logic [ABITS-1:0] addr_q;
    logic [DBITS-1:0] wdata_q;
    logic [DBITS-1:0] rdata_q;
    logic             err_q;
    logic             tout_q;
    logic [15:0]      wait_cnt;
    logic [15:0]      err_cnt_q;
    logic [NREQ-1:0]  req_ready_c;
    logic [NREQ-1:0]  rsp_valid_c;
    logic             wait_expired;

    assign wait_expired = (wait_cnt == 16'(TOUT - 1));

    // Scan downward so the last hit is the first valid requester at or after ptr.
    always_comb begin
        win       = ptr;
        idx       = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (bus.req_valid[idx]) begin
                win       = idx;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = '0;
        rsp_valid_c = '0;
        unique case (state)
            S_IDLE: begin
                if (any_valid && !apb_rst) begin
                    req_ready_c = NREQ'(1) << win;
                    state_nxt   = S_SETUP;
                end
            end
            S_SETUP: state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (bus.apb_ready || wait_expired) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_c = NREQ'(1) << win_q;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            win_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            tout_q    <= 1'b0;
            wait_cnt  <= '0;
            err_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        win_q    <= win;
                        write_q  <= bus.req_write[win];
                        addr_q   <= bus.req_addr[int'(win) * ABITS +: ABITS];
                        wdata_q  <= bus.req_wdata[int'(win) * DBITS +: DBITS];
                        wait_cnt <= '0;
                    end
                end
                S_SETUP: begin
                    ptr <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
                end
                S_ACCESS: begin
                    if (bus.apb_ready) begin
                        rdata_q <= write_q ? '0 : bus.apb_rdata;
                        err_q   <= bus.apb_slverr;
                        tout_q  <= 1'b0;
                    end else if (wait_expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        tout_q  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (err_q && err_cnt_q != 16'hFFFF) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_rdata  = (state == S_RESP) ? rdata_q : '0;
    assign bus.rsp_err    = (state == S_RESP) && err_q;
    assign bus.rsp_tout   = (state == S_RESP) && tout_q;
    assign bus.apb_sel    = (state == S_SETUP) || (state == S_ACCESS);
    assign bus.apb_enable = (state == S_ACCESS);
    assign bus.apb_write  = write_q;
    assign bus.apb_addr   = addr_q;
    assign bus.apb_wdata  = wdata_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;
    localparam int NREQ  = 4;
    localparam int DBITS = 32;
    localparam int ABITS = 16;
    localparam int TOUT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    apb_master_arbiter_if #(.NREQ(NREQ), .DBITS(DBITS), .ABITS(ABITS)) bus();

    apb_master_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .ABITS(ABITS), .TOUT(TOUT)) dut (
        .apb_clk(clk),
        .apb_rst(rst),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.apb_rdata  = '0;
        bus.apb_ready  = 1'b0;
        bus.apb_slverr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ready: got %b expected 0000", bus.req_ready); end
        vectors++; if ({bus.apb_sel, bus.apb_enable, bus.apb_write} !== 3'b000) begin miscompares++; $display("FAIL rst_apb_ctl: got %b expected 000", {bus.apb_sel, bus.apb_enable, bus.apb_write}); end
        vectors++; if ({bus.apb_addr, bus.apb_wdata} !== 48'h0) begin miscompares++; $display("FAIL rst_apb_data: got %h expected 0", {bus.apb_addr, bus.apb_wdata}); end
        vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_tout} !== 6'b0) begin miscompares++; $display("FAIL rst_rsp: got %b expected 000000", {bus.rsp_valid, bus.rsp_err, bus.rsp_tout}); end
        vectors++; if ({bus.rsp_rdata, bus.err_cnt} !== 48'h0) begin miscompares++; $display("FAIL rst_rdata_errcnt: got %h expected 0", {bus.rsp_rdata, bus.err_cnt}); end
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.req_valid = 4'b0001; bus.req_write = 4'b0001;
        bus.req_addr[0 +: 16] = 16'h0004; bus.req_wdata[0 +: 32] = 32'h11;
        #1;
        vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL wr_grant: got %b expected 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0; bus.apb_ready = 1'b1;
        #1;
        vectors++; if ({bus.apb_sel, bus.apb_enable, bus.apb_write} !== 3'b101) begin miscompares++; $display("FAIL wr_setup_ctl: got %b expected 101", {bus.apb_sel, bus.apb_enable, bus.apb_write}); end
        vectors++; if (bus.apb_addr !== 16'h0004) begin miscompares++; $display("FAIL wr_setup_addr: got %h expected 0004", bus.apb_addr); end
        vectors++; if (bus.apb_wdata !== 32'h11) begin miscompares++; $display("FAIL wr_setup_wdata: got %h expected 00000011", bus.apb_wdata); end
        vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL wr_ready_pulse: got %b expected 0000", bus.req_ready); end
        @(negedge clk); #1;
        vectors++; if ({bus.apb_sel, bus.apb_enable} !== 2'b11) begin miscompares++; $display("FAIL wr_access_ctl: got %b expected 11", {bus.apb_sel, bus.apb_enable}); end
        @(negedge clk);
        bus.apb_ready = 1'b0;
        #1;
        vectors++; if (bus.rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL wr_rsp_valid: got %b expected 0001", bus.rsp_valid); end
        vectors++; if ({bus.rsp_err, bus.rsp_tout} !== 2'b00) begin miscompares++; $display("FAIL wr_rsp_err: got %b expected 00", {bus.rsp_err, bus.rsp_tout}); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL wr_rsp_rdata: got %h expected 0", bus.rsp_rdata); end
        vectors++; if ({bus.apb_sel, bus.apb_enable} !== 2'b00) begin miscompares++; $display("FAIL wr_resp_ctl: got %b expected 00", {bus.apb_sel, bus.apb_enable}); end
        @(negedge clk); #1;
        vectors++; if (bus.rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL wr_rsp_pulse: got %b expected 0000", bus.rsp_valid); end
    endtask

    task automatic test_wait_read();
        int en_cycles = 0;
        @(negedge clk);
        bus.req_valid = 4'b0010; bus.req_write = 4'b0000; bus.req_addr[16 +: 16] = 16'h0010;
        #1;
        vectors++; if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL rd_grant: got %b expected 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        vectors++; if ({bus.apb_sel, bus.apb_enable, bus.apb_write} !== 3'b100) begin miscompares++; $display("FAIL rd_setup_ctl: got %b expected 100", {bus.apb_sel, bus.apb_enable, bus.apb_write}); end
        vectors++; if (bus.apb_addr !== 16'h0010) begin miscompares++; $display("FAIL rd_setup_addr: got %h expected 0010", bus.apb_addr); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin bus.apb_ready = 1'b1; bus.apb_rdata = 32'hDEADBEEF; end
            #1;
            if (bus.apb_enable === 1'b1) en_cycles++;
        end
        @(negedge clk);
        bus.apb_ready = 1'b0; bus.apb_rdata = '0;
        #1;
        vectors++; if (en_cycles !== 4) begin miscompares++; $display("FAIL rd_enable_cycles: got %0d expected 4", en_cycles); end
        vectors++; if (bus.rsp_valid !== 4'b0010) begin miscompares++; $display("FAIL rd_rsp_valid: got %b expected 0010", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_rsp_rdata: got %h expected deadbeef", bus.rsp_rdata); end
        vectors++; if ({bus.rsp_err, bus.apb_enable} !== 2'b00) begin miscompares++; $display("FAIL rd_rsp_err_en: got %b expected 00", {bus.rsp_err, bus.apb_enable}); end
        @(negedge clk);
    endtask

    task automatic test_slave_error();
        @(negedge clk);
        bus.req_valid = 4'b0100; bus.req_write = 4'b0100;
        bus.req_addr[32 +: 16] = 16'h0020; bus.req_wdata[64 +: 32] = 32'h55;
        #1;
        vectors++; if (bus.req_ready !== 4'b0100) begin miscompares++; $display("FAIL se_grant: got %b expected 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0; bus.apb_ready = 1'b1; bus.apb_slverr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.apb_ready = 1'b0; bus.apb_slverr = 1'b0;
        #1;
        vectors++; if (bus.rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL se_rsp_valid: got %b expected 0100", bus.rsp_valid); end
        vectors++; if ({bus.rsp_err, bus.rsp_tout} !== 2'b10) begin miscompares++; $display("FAIL se_rsp_err: got %b expected 10", {bus.rsp_err, bus.rsp_tout}); end
        vectors++; if (bus.err_cnt !== 16'd0) begin miscompares++; $display("FAIL se_errcnt_before: got %0d expected 0", bus.err_cnt); end
        @(negedge clk); #1;
        vectors++; if (bus.err_cnt !== 16'd1) begin miscompares++; $display("FAIL se_errcnt_after: got %0d expected 1", bus.err_cnt); end
    endtask

    task automatic test_timeout();
        int acc = 0;
        bit got = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b1000; bus.req_write = 4'b0000; bus.req_addr[48 +: 16] = 16'h0030;
        #1;
        vectors++; if (bus.req_ready !== 4'b1000) begin miscompares++; $display("FAIL to_grant: got %b expected 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            if (bus.apb_enable === 1'b1) acc++;
            if (bus.rsp_valid !== 4'b0000) got = 1'b1;
        end
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL to_rsp_seen: got %b expected 1", got); end
        vectors++; if (acc !== TOUT) begin miscompares++; $display("FAIL to_access_cycles: got %0d expected %0d", acc, TOUT); end
        vectors++; if (bus.rsp_valid !== 4'b1000) begin miscompares++; $display("FAIL to_rsp_valid: got %b expected 1000", bus.rsp_valid); end
        vectors++; if ({bus.rsp_err, bus.rsp_tout} !== 2'b11) begin miscompares++; $display("FAIL to_rsp_err: got %b expected 11", {bus.rsp_err, bus.rsp_tout}); end
        @(negedge clk); #1;
        vectors++; if (bus.err_cnt !== 16'd2) begin miscompares++; $display("FAIL to_errcnt: got %0d expected 2", bus.err_cnt); end
        @(negedge clk);
        bus.req_valid = 4'b0001; bus.req_write = 4'b0001; bus.req_addr[0 +: 16] = 16'h0008; bus.apb_ready = 1'b1;
        #1;
        vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL to_next_grant: got %b expected 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        bus.apb_ready = 1'b0;
        #1;
        vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_tout} !== 6'b000100) begin miscompares++; $display("FAIL to_next_rsp: got %b expected 000100", {bus.rsp_valid, bus.rsp_err, bus.rsp_tout}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        bus.req_valid = 4'b0001; bus.req_write = 4'b0001; bus.req_addr[0 +: 16] = 16'h0044;
        #1;
        vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL rma_grant: got %b expected 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk); #1;
        vectors++; if (bus.apb_enable !== 1'b1) begin miscompares++; $display("FAIL rma_in_access: got %b expected 1", bus.apb_enable); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if ({bus.apb_sel, bus.apb_enable, bus.apb_addr} !== 18'h0) begin miscompares++; $display("FAIL rma_async_drop: got %h expected 0", {bus.apb_sel, bus.apb_enable, bus.apb_addr}); end
        vectors++; if (bus.err_cnt !== 16'd0) begin miscompares++; $display("FAIL rma_errcnt_clear: got %0d expected 0", bus.err_cnt); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            vectors++; if (bus.rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL rma_no_rsp: got %b expected 0000", bus.rsp_valid); end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 4'b0011; bus.req_write = 4'b0011; bus.apb_ready = 1'b1;
        #1;
        vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL rma_ptr_reset: got %b expected 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        @(negedge clk); #1;
        vectors++; if (bus.rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL rma_rsp_after: got %b expected 0001", bus.rsp_valid); end
        @(negedge clk); #1;
        vectors++; if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL rma_waiter_grant: got %b expected 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [3:0] grants [8];
        int ng = 0;
        for (int i = 0; i < 8; i++) grants[i] = '0;
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 4'b1111; bus.req_write = 4'b1111; bus.apb_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (bus.req_ready !== 4'b0000) begin
                if (ng < 8) grants[ng] = bus.req_ready;
                ng++;
            end
        end
        @(negedge clk);
        bus.req_valid = '0; bus.apb_ready = 1'b0;
        vectors++; if (ng !== 6) begin miscompares++; $display("FAIL rr_grant_count: got %0d expected 6", ng); end
        for (int i = 0; i < 6; i++) begin
            vectors++; if (grants[i] !== exp_g[i]) begin miscompares++; $display("FAIL rr_order[%0d]: got %b expected %b", i, grants[i], exp_g[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wait_read();
        test_slave_error();
        test_timeout();
        test_reset_mid_access();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
